// File: rtl/slave_in_port.sv
// slave_in_port: bus-side receive port of a slave (responder end of the serial
// master->slave request protocol).
//
// A request is accepted on the master_valid/slave_ready handshake. The address
// and, for writes, the data are then shifted in one bit per cycle, LSB first,
// on parallel lines. A single-cycle write or read strobe is then issued to the
// slave's local memory. Read data return is handled elsewhere. Only
// mem_rvalid is observed here, to know when the read is finished.
//
// Optional feature (compile-time macro SLAVE_ADDR_RANGE_CHECK_EN):
//   When defined, an assembled address >= MEM_DEPTH suppresses the memory
//   strobe and pulses rx_error together with rx_done instead.
//   When undefined, rx_error stays 0 and every address is forwarded.
//
// Parameters (ADDR_LEN and DATA_LEN must both be at least 2):
//   ADDR_LEN   address width, serial address bits per request
//   DATA_LEN   data width, serial data bits per write
//   MEM_DEPTH  number of valid memory locations (range check only)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   master_valid  master holds a request for the whole transfer
//   write_en      request is a write (sampled at handshake)
//   read_en       request is a read (sampled at handshake)
//   rx_address    serial address bit
//   rx_data       serial data bit (writes only)
//   slave_ready   slave can accept a new request
//   mem_addr      assembled address to local memory
//   mem_wdata     assembled write data
//   mem_wen       one-cycle write strobe
//   mem_ren       one-cycle read strobe
//   mem_rvalid    memory read completed
//   rx_done       one-cycle pulse when the request is finished
//   rx_error      one-cycle address-range error pulse

module slave_in_port #(
    parameter int unsigned ADDR_LEN  = 12,
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned MEM_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_wen,
    output logic                mem_ren,
    input  logic                mem_rvalid,
    output logic                rx_done,
    output logic                rx_error
);

    // Writes last as long as the longer of the two serial words.
    localparam int unsigned WR_LEN = (DATA_LEN > ADDR_LEN) ? DATA_LEN : ADDR_LEN;
    localparam int unsigned CNT_W  = $clog2(WR_LEN + 1);

    localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(ADDR_LEN);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_LEN);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(ADDR_LEN - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReceive,
        StMemAccess,
        StWaitRead
    } state_t;

    state_t              state;
    logic                is_write;
    logic [ADDR_LEN-1:0] addr_sr;
    logic [DATA_LEN-1:0] data_sr;
    logic [CNT_W-1:0]    count;

    logic             valid_req;
    logic [CNT_W-1:0] last_cnt;
    logic             addr_oob;

    // A request with both or neither enable set is simply not a request.
    assign valid_req = master_valid & slave_ready & (write_en ^ read_en);
    assign last_cnt  = is_write ? WR_LAST : RD_LAST;

`ifdef SLAVE_ADDR_RANGE_CHECK_EN
    assign addr_oob = 64'(addr_sr) >= 64'(MEM_DEPTH);
`else
    assign addr_oob = 1'b0;
    logic unused_mem_depth;
    assign unused_mem_depth = ^MEM_DEPTH;
`endif

    // Serial words arrive LSB first. Each new bit enters at the MSB and the
    // word shifts right, so after the final bit, bit 0 sits at position 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            slave_ready <= 1'b1;
            is_write    <= 1'b0;
            addr_sr     <= '0;
            data_sr     <= '0;
            count       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
            rx_done     <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
            rx_done  <= 1'b0;
            rx_error <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (valid_req) begin
                        is_write    <= write_en;
                        addr_sr     <= {rx_address, {(ADDR_LEN-1){1'b0}}};
                        data_sr     <= write_en ? {rx_data, {(DATA_LEN-1){1'b0}}} : '0;
                        count       <= CNT_W'(1);
                        slave_ready <= 1'b0;
                        state       <= StReceive;
                    end else begin
                        // Also raises ready one cycle after a finished write.
                        slave_ready <= 1'b1;
                    end
                end

                StReceive: begin
                    if (!master_valid) begin
                        // Master gave up: drop the partial words, no strobe.
                        count       <= '0;
                        slave_ready <= 1'b1;
                        state       <= StIdle;
                    end else begin
                        if (count < ADDR_CNT) begin
                            addr_sr <= {rx_address, addr_sr[ADDR_LEN-1:1]};
                        end
                        if (is_write && (count < DATA_CNT)) begin
                            data_sr <= {rx_data, data_sr[DATA_LEN-1:1]};
                        end
                        count <= count + CNT_W'(1);
                        if (count == last_cnt) begin
                            state <= StMemAccess;
                        end
                    end
                end

                StMemAccess: begin
                    mem_addr  <= addr_sr;
                    mem_wdata <= data_sr;
                    count     <= '0;
                    if (addr_oob) begin
                        rx_error <= 1'b1;
                        rx_done  <= 1'b1;
                        state    <= StIdle;
                    end else if (is_write) begin
                        mem_wen <= 1'b1;
                        rx_done <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        mem_ren <= 1'b1;
                        state   <= StWaitRead;
                    end
                end

                StWaitRead: begin
                    // mem_rvalid is first looked at on the edge after the strobe.
                    if (mem_rvalid) begin
                        rx_done     <= 1'b1;
                        slave_ready <= 1'b1;
                        state       <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_in_port.sv
// Self-checking bench for slave_in_port (ADDR_LEN=12, DATA_LEN=8, MEM_DEPTH=2048).
// Expected transactions are queued when a request is launched and popped when
// the DUT issues its strobe. Inputs change and outputs are sampled on the
// falling clock edge.

module tb_slave_in_port;

    localparam int unsigned AL = 12;
    localparam int unsigned DL = 8;
`ifdef SLAVE_ADDR_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    typedef struct {
        bit            wr;
        bit            err;
        logic [AL-1:0] addr;
        logic [DL-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          master_valid;
    logic          write_en;
    logic          read_en;
    logic          rx_address;
    logic          rx_data;
    logic          slave_ready;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_wen;
    logic          mem_ren;
    logic          mem_rvalid;
    logic          rx_done;
    logic          rx_error;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_wen = 0, exp_ren = 0, exp_done = 0, exp_err = 0;

    // Written only by the monitor process.
    int   wen_count = 0, ren_count = 0, done_count = 0, err_count = 0;
    bit   inv_bad = 1'b0;
    logic prev_wen = 1'b0, prev_ren = 1'b0;

    always #5 clk = ~clk;

    slave_in_port #(
        .ADDR_LEN (AL),
        .DATA_LEN (DL),
        .MEM_DEPTH(2048)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .master_valid(master_valid),
        .write_en    (write_en),
        .read_en     (read_en),
        .rx_address  (rx_address),
        .rx_data     (rx_data),
        .slave_ready (slave_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_ren     (mem_ren),
        .mem_rvalid  (mem_rvalid),
        .rx_done     (rx_done),
        .rx_error    (rx_error)
    );

    // Strobe counters and invariants, sampled just before each rising edge.
    initial begin : monitor
        forever begin
            @(posedge clk);
            if (reset !== 1'b1) begin
                if (mem_wen === 1'b1) wen_count++;
                if (mem_ren === 1'b1) ren_count++;
                if (rx_done === 1'b1) done_count++;
                if (rx_error === 1'b1) err_count++;
                if ((mem_wen === 1'b1) && (mem_ren === 1'b1)) inv_bad = 1'b1;
                if ((mem_wen === 1'b1) && (prev_wen === 1'b1)) inv_bad = 1'b1;
                if ((mem_ren === 1'b1) && (prev_ren === 1'b1)) inv_bad = 1'b1;
            end
            prev_wen = mem_wen;
            prev_ren = mem_ren;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Present bits 0..nbits-1 of a request, one per cycle. Returns on the falling
    // edge after the last bit was clocked. Bits beyond a word's width are random.
    task automatic drive_request(input bit wr, input logic [AL-1:0] addr,
                                 input logic [DL-1:0] data, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            master_valid = 1'b1;
            write_en     = wr;
            read_en      = !wr;
            rx_address   = (k < AL) ? addr[k] : 1'($urandom_range(1, 0));
            rx_data      = (wr && (k < DL)) ? data[k] : 1'($urandom_range(1, 0));
            @(negedge clk);
        end
    endtask

    task automatic release_bus();
        master_valid = 1'b0;
        write_en     = 1'b0;
        read_en      = 1'b0;
        rx_address   = 1'b0;
        rx_data      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        release_bus();
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (slave_ready !== 1'b1) begin miscompares++;
            $display("FAIL reset_ready: got %b expected 1", slave_ready); end
        vectors++; if ({mem_wen, mem_ren, rx_done, rx_error} !== 4'b0000) begin miscompares++;
            $display("FAIL reset_pulses: got %b expected 0000",
                     {mem_wen, mem_ren, rx_done, rx_error}); end
        vectors++; if ({mem_addr, mem_wdata} !== 20'h0) begin miscompares++;
            $display("FAIL reset_mem_bus: got %h expected 00000", {mem_addr, mem_wdata}); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (slave_ready !== 1'b1) begin miscompares++;
            $display("FAIL idle_ready: got %b expected 1", slave_ready); end
    endtask

    task automatic test_write(input logic [AL-1:0] addr, input logic [DL-1:0] data);
        exp_t e;
        e.wr   = 1'b1;
        e.err  = RANGE_ON && (addr >= 12'd2048);
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
        if (e.err) exp_err++; else exp_wen++;
        exp_done++;
        drive_request(1'b1, addr, data, AL);
        release_bus();
        @(negedge clk);
        e = sb.pop_front();
        vectors++; if (mem_wen !== !e.err) begin miscompares++;
            $display("FAIL wr_strobe %h: got %b expected %b", e.addr, mem_wen, !e.err); end
        vectors++; if (rx_error !== e.err) begin miscompares++;
            $display("FAIL wr_error %h: got %b expected %b", e.addr, rx_error, e.err); end
        vectors++; if ({rx_done, mem_ren, slave_ready} !== 3'b100) begin miscompares++;
            $display("FAIL wr_done_ren_ready %h: got %b expected 100", e.addr,
                     {rx_done, mem_ren, slave_ready}); end
        vectors++; if (mem_addr !== e.addr) begin miscompares++;
            $display("FAIL wr_addr: got %h expected %h", mem_addr, e.addr); end
        vectors++; if (mem_wdata !== e.data) begin miscompares++;
            $display("FAIL wr_data: got %h expected %h", mem_wdata, e.data); end
        @(negedge clk);
        vectors++; if ({mem_wen, rx_done, rx_error, slave_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL wr_after %h: got %b expected 0001", e.addr,
                     {mem_wen, rx_done, rx_error, slave_ready}); end
    endtask

    // delay: falling edges after the read strobe before mem_rvalid is raised.
    task automatic test_read(input logic [AL-1:0] addr, input int delay);
        exp_t e;
        e.wr   = 1'b0;
        e.err  = 1'b0;
        e.addr = addr;
        e.data = '0;
        sb.push_back(e);
        exp_ren++;
        exp_done++;
        drive_request(1'b0, addr, '0, AL);
        release_bus();
        @(negedge clk);
        e = sb.pop_front();
        vectors++; if ({mem_ren, mem_wen, rx_done, slave_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rd_strobe %h: got %b expected 1000", e.addr,
                     {mem_ren, mem_wen, rx_done, slave_ready}); end
        vectors++; if (mem_addr !== e.addr) begin miscompares++;
            $display("FAIL rd_addr: got %h expected %h", mem_addr, e.addr); end
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            vectors++; if ({mem_ren, rx_done, slave_ready} !== 3'b000) begin miscompares++;
                $display("FAIL rd_wait cycle %0d: got %b expected 000", i,
                         {mem_ren, rx_done, slave_ready}); end
        end
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        vectors++; if ({rx_done, slave_ready, mem_ren} !== 3'b110) begin miscompares++;
            $display("FAIL rd_done: got %b expected 110", {rx_done, slave_ready, mem_ren}); end
        @(negedge clk);
        vectors++; if ({rx_done, slave_ready} !== 2'b01) begin miscompares++;
            $display("FAIL rd_after: got %b expected 01", {rx_done, slave_ready}); end
    endtask

    task automatic test_abort();
        int w0, d0;
        drive_request(1'b1, 12'h123, 8'h77, 6);
        release_bus();
        @(negedge clk);
        w0 = exp_wen;
        d0 = exp_done;
        vectors++; if ({slave_ready, mem_wen, rx_done} !== 3'b100) begin miscompares++;
            $display("FAIL abort_ready: got %b expected 100", {slave_ready, mem_wen, rx_done}); end
        repeat (AL + 3) @(negedge clk);
        vectors++; if (wen_count !== w0) begin miscompares++;
            $display("FAIL abort_no_wen: got %0d strobes expected %0d", wen_count, w0); end
        vectors++; if (done_count !== d0) begin miscompares++;
            $display("FAIL abort_no_done: got %0d pulses expected %0d", done_count, d0); end
        test_write(12'h00A, 8'h55);
    endtask

    task automatic test_illegal_then_reset();
        for (int i = 0; i < 5; i++) begin
            master_valid = 1'b1;
            write_en     = 1'b1;
            read_en      = 1'b1;
            rx_address   = 1'b1;
            rx_data      = 1'b1;
            @(negedge clk);
            vectors++; if (slave_ready !== 1'b1) begin miscompares++;
                $display("FAIL illegal_ready cycle %0d: got %b expected 1", i, slave_ready); end
        end
        release_bus();
        drive_request(1'b1, 12'h3FF, 8'hAA, 5);
        reset = 1'b1;
        release_bus();
        @(negedge clk);
        reset = 1'b0;
        vectors++; if (slave_ready !== 1'b1) begin miscompares++;
            $display("FAIL midreset_ready: got %b expected 1", slave_ready); end
        vectors++; if ({mem_addr, mem_wdata} !== 20'h0) begin miscompares++;
            $display("FAIL midreset_bus: got %h expected 00000", {mem_addr, mem_wdata}); end
        repeat (AL + 3) @(negedge clk);
        vectors++; if ((wen_count !== exp_wen) || (done_count !== exp_done)) begin
            miscompares++;
            $display("FAIL midreset_no_strobe: got wen %0d done %0d expected %0d %0d",
                     wen_count, done_count, exp_wen, exp_done); end
        vectors++; if (slave_ready !== 1'b1) begin miscompares++;
            $display("FAIL midreset_idle: got %b expected 1", slave_ready); end
    endtask

    task automatic test_range();
        test_write(12'h900, 8'h3C);
        test_write(12'h100, 8'h3C);
    endtask

    task automatic test_back_to_back();
        test_write(12'h7FF, 8'h81);
        test_read(12'h001, 0);
        test_write(12'hFFE, 8'h01);
    endtask

    task automatic test_totals();
        vectors++; if (sb.size() !== 0) begin miscompares++;
            $display("FAIL sb_empty: got %0d left expected 0", sb.size()); end
        vectors++; if (wen_count !== exp_wen) begin miscompares++;
            $display("FAIL total_wen: got %0d expected %0d", wen_count, exp_wen); end
        vectors++; if (ren_count !== exp_ren) begin miscompares++;
            $display("FAIL total_ren: got %0d expected %0d", ren_count, exp_ren); end
        vectors++; if (done_count !== exp_done) begin miscompares++;
            $display("FAIL total_done: got %0d expected %0d", done_count, exp_done); end
        vectors++; if (err_count !== exp_err) begin miscompares++;
            $display("FAIL total_err: got %0d expected %0d", err_count, exp_err); end
        vectors++; if (inv_bad !== 1'b0) begin miscompares++;
            $display("FAIL strobe_invariant: got %b expected 0", inv_bad); end
    endtask

    initial begin : main
        test_reset();
        test_write(12'h5A3, 8'hC4);
        test_read(12'h0FF, 3);
        test_abort();
        test_illegal_then_reset();
        test_range();
        test_back_to_back();
        test_totals();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
